dmem_responder: RTL

//  Responder (memory) end of the core's data-memory load/store interface. Accepts one

---
 rtl/mem_pkg.sv | 27 ++
 rtl/ls_align.sv | 54 +++++
 rtl/dmem_responder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared load/store definitions: access-size encoding, responder FSM states and
// the alignment rule used to flag misaligned accesses.
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_type_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_RESP = 2'b10
  } dmem_state_e;

  // Half needs an even address, word needs a 4-byte aligned address; the
  // illegal size code is reported separately by the caller.
  function automatic logic misaligned(input logic [1:0] typ, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (typ == MEM_HALF) bad = off[0];
    else if (typ == MEM_WORD) bad = (off != 2'b00);
    return bad;
  endfunction

endpackage

// File: rtl/ls_align.sv
// Combinational byte-lane steering: builds per-byte write enables plus a
// lane-replicated store word, and extracts/extends load data from a RAM word.
module ls_align
  import mem_pkg::*;
(
  input  logic [1:0]  type_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wword_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // Store side: replicate the right-aligned data so every candidate lane holds it,
  // then let the byte enables pick which lanes are actually written.
  always_comb begin
    be_o    = 4'b0000;
    wword_o = wdata_i;
    case (type_i)
      MEM_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wword_o = {4{wdata_i[7:0]}};
      end
      MEM_HALF: begin
        be_o    = off_i[1] ? 4'b1100 : 4'b0011;
        wword_o = {2{wdata_i[15:0]}};
      end
      MEM_WORD: begin
        be_o    = 4'b1111;
        wword_o = wdata_i;
      end
      default: be_o = 4'b0000;
    endcase
  end

  // Load side: shift the addressed lane(s) down to bit 0, then extend.
  always_comb begin
    shifted = rword_i >> {off_i, 3'b000};
    rdata_o = 32'h0;
    case (type_i)
      MEM_BYTE: rdata_o = sign_i ? {{24{shifted[7]}}, shifted[7:0]}
                                 : {24'h0, shifted[7:0]};
      MEM_HALF: rdata_o = sign_i ? {{16{shifted[15]}}, shifted[15:0]}
                                 : {16'h0, shifted[15:0]};
      MEM_WORD: rdata_o = rword_i;
      default:  rdata_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, LATENCY wait states, then a
// registered response held until the requester takes it.
// Handshake rule: a transfer happens on a rising edge where valid and ready are both
// high; valid, once raised, holds its payload stable until that edge.
module dmem_responder
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic                  req_we_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]            req_type_i,
  input  logic                  req_sign_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output dmem_state_e           state_o
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  dmem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q;
  logic        we_q, sign_q;
  logic [1:0]  type_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;
  logic        latch, commit, err;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic [3:0]  be;
  logic [31:0] wword, rdata_ext;

  assign idx = addr_q[AW+1:2];
  assign err = (type_q == 2'b11) || misaligned(type_q, addr_q[1:0]) ||
               (addr_q[31:2] >= DEPTH_LIM);

  ls_align u_align (
    .type_i  (type_q),
    .sign_i  (sign_q),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rword_i (mem_q[idx]),
    .be_o    (be),
    .wword_o (wword),
    .rdata_o (rdata_ext)
  );

  // Next-state logic: the counter runs down to zero in WAIT, and the edge that
  // sees zero commits, so the response lands LATENCY+1 edges after the accept.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch       = 1'b0;
    commit      = 1'b0;
    req_ready_o = (state_q == S_IDLE);
    rsp_valid_o = (state_q == S_RESP);
    case (state_q)
      S_IDLE: if (req_valid_i) begin
        latch   = 1'b1;
        state_d = S_WAIT;
        cnt_d   = 4'(LATENCY);
      end
      S_WAIT: if (cnt_q == 4'd0) begin
        commit  = 1'b1;
        state_d = S_RESP;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request capture and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      we_q        <= 1'b0;
      sign_q      <= 1'b0;
      type_q      <= 2'b00;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        we_q    <= req_we_i;
        sign_q  <= req_sign_i;
        type_q  <= req_type_i;
      end
      if (commit) begin
        rsp_err_q   <= err;
        rsp_rdata_q <= (err || we_q) ? 32'h0 : rdata_ext;
      end else if (state_q == S_RESP && rsp_ready_i) begin
        rsp_err_q   <= 1'b0;
        rsp_rdata_q <= 32'h0;
      end
    end
  end

  // Backing RAM: per-byte write on commit of an error-free store; never reset.
  always_ff @(posedge clk) begin
    if (!rst && commit && we_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign state_o     = state_q;

endmodule
